// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        ERR  = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        BR   = 2'd1,
        JMP  = 2'd2,
        JR   = 2'd3
    } redirect_sel_e;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_next_pc_calc.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_calc
// Purpose  : Combinational redirect priority (jr > jmp > br) and next-pc
//            arithmetic. IFETCH_ALIGN_CHECK_EN keeps raw jr low bits.
// Revision : 1.0 - initial release
// ============================================================================
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] instr_pc,
    input  logic            fire,
    input  logic            br_taken,
    input  logic [15:0]     br_offset,
    input  logic            jmp,
    input  logic [25:0]     jmp_index,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_target,
    output redirect_sel_e   sel,
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0] w_seq;
    logic [PC_W-1:0] w_br_target;
    logic [PC_W-1:0] w_jmp_target;
    logic [PC_W-1:0] w_jr_target;

    assign w_seq        = instr_pc + PC_W'(PC_STEP);
    assign w_br_target  = w_seq + {{(PC_W-18){br_offset[15]}}, br_offset, 2'b00};
    assign w_jmp_target = {w_seq[PC_W-1:28], jmp_index, 2'b00};

`ifdef IFETCH_ALIGN_CHECK_EN
    // Misaligned targets are trapped by the caller before they are used.
    assign w_jr_target = jr_target;
`else
    assign w_jr_target = jr_target & {{(PC_W-2){1'b1}}, 2'b00};
`endif

    always_comb begin
        sel     = NONE;
        next_pc = pc + PC_W'(PC_STEP);
        if (fire) begin
            if (jr) begin
                sel     = JR;
                next_pc = w_jr_target;
            end else if (jmp) begin
                sel     = JMP;
                next_pc = w_jmp_target;
            end else if (br_taken) begin
                sel     = BR;
                next_pc = w_br_target;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : PC register and fetch stage with valid/ready output, redirects,
//            stall and halt. Option macro: IFETCH_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            br_taken,
    input  logic [15:0]     br_offset,
    input  logic            jmp,
    input  logic [25:0]     jmp_index,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_target,
    input  logic            halt,
    output logic            halted,
    output logic            misalign_err
);

    fetch_state_e    r_state_q,       w_state_d;
    logic [PC_W-1:0] r_pc_q,          w_pc_d;
    logic [31:0]     r_instr_q,       w_instr_d;
    logic [PC_W-1:0] r_instr_pc_q,    w_instr_pc_d;
    logic            r_instr_valid_q, w_instr_valid_d;
    logic            r_halted_q,      w_halted_d;

    logic            w_fire;
    logic            w_load;
    redirect_sel_e   w_sel;
    logic [PC_W-1:0] w_next_pc;

    assign w_fire = r_instr_valid_q & instr_ready;
    assign w_load = ~r_instr_valid_q | instr_ready;

    next_pc_calc #(
        .PC_W (PC_W)
    ) u_next_pc_calc (
        .pc        (r_pc_q),
        .instr_pc  (r_instr_pc_q),
        .fire      (w_fire),
        .br_taken  (br_taken),
        .br_offset (br_offset),
        .jmp       (jmp),
        .jmp_index (jmp_index),
        .jr        (jr),
        .jr_target (jr_target),
        .sel       (w_sel),
        .next_pc   (w_next_pc)
    );

`ifdef IFETCH_ALIGN_CHECK_EN
    logic r_misalign_q, w_misalign_d;
    logic w_jr_misaligned;
    assign w_jr_misaligned = |jr_target[1:0];
    assign misalign_err    = r_misalign_q;
`else
    assign misalign_err    = 1'b0;
`endif

    always_comb begin
        w_state_d       = r_state_q;
        w_pc_d          = r_pc_q;
        w_instr_d       = r_instr_q;
        w_instr_pc_d    = r_instr_pc_q;
        w_instr_valid_d = r_instr_valid_q;
        w_halted_d      = r_halted_q;
`ifdef IFETCH_ALIGN_CHECK_EN
        w_misalign_d    = r_misalign_q;
`endif
        case (r_state_q)
            RUN: begin
                // Halt outranks any redirect presented alongside it.
                if (w_fire && halt) begin
                    w_state_d       = HALT;
                    w_instr_valid_d = 1'b0;
                    w_halted_d      = 1'b1;
                end
`ifdef IFETCH_ALIGN_CHECK_EN
                else if (w_sel == JR && w_jr_misaligned) begin
                    w_state_d       = ERR;
                    w_instr_valid_d = 1'b0;
                    w_halted_d      = 1'b1;
                    w_misalign_d    = 1'b1;
                end
`endif
                else if (w_sel != NONE) begin
                    w_pc_d          = w_next_pc;
                    w_instr_valid_d = 1'b0;
                end else if (w_load) begin
                    w_instr_d       = imem_data;
                    w_instr_pc_d    = r_pc_q;
                    w_instr_valid_d = 1'b1;
                    w_pc_d          = w_next_pc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q       <= RUN;
            r_pc_q          <= RESET_PC;
            r_instr_q       <= '0;
            r_instr_pc_q    <= '0;
            r_instr_valid_q <= 1'b0;
            r_halted_q      <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
            r_misalign_q    <= 1'b0;
`endif
        end else begin
            r_state_q       <= w_state_d;
            r_pc_q          <= w_pc_d;
            r_instr_q       <= w_instr_d;
            r_instr_pc_q    <= w_instr_pc_d;
            r_instr_valid_q <= w_instr_valid_d;
            r_halted_q      <= w_halted_d;
`ifdef IFETCH_ALIGN_CHECK_EN
            r_misalign_q    <= w_misalign_d;
`endif
        end
    end

    assign imem_addr   = r_pc_q;
    assign instr       = r_instr_q;
    assign instr_pc    = r_instr_pc_q;
    assign instr_valid = r_instr_valid_q;
    assign halted      = r_halted_q;

endmodule
`default_nettype wire
